cmu: RTL and testbench

CMU -- requirements
Module: cmu

---
 rtl/cmu_pkg.sv | 23 ++
 rtl/cmu_cache.sv | 133 +++++++++++++
 rtl/cmu.sv | 149 ++++++++++++++
 tb/tb_cmu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmu_pkg.sv
// Shared definitions for the 2-way write-back data cache.
// FSM encoding, access-size codes and default geometry.
package cmu_pkg;

    localparam int CMU_LINE_WORDS = 4;
    localparam int CMU_SETS       = 64;
    localparam int WORD_BITS      = $clog2(CMU_LINE_WORDS);
    localparam int INDEX_BITS     = $clog2(CMU_SETS);
    localparam int TAG_BITS       = 32 - 2 - WORD_BITS - INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BACK,
        S_FILL,
        S_WAIT
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam int         UNS_BIT = 2;

endpackage

// File: rtl/cmu_cache.sv
// Cache storage: tag/valid/dirty/data/LRU arrays, hit detection,
// load extension, store byte-lane merge and victim selection.
module cmu_cache
    import cmu_pkg::*;
#(
    parameter int LINE_WORDS = CMU_LINE_WORDS,
    parameter int SETS       = CMU_SETS,
    localparam int WB = $clog2(LINE_WORDS),
    localparam int IB = $clog2(SETS),
    localparam int TB = 30 - WB - IB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          acc,
    input  logic          wr,
    input  logic [31:0]   addr,
    input  logic [2:0]    ubhw,
    input  logic [31:0]   data_w,
    output logic          hit,
    output logic [31:0]   data_r,
    output logic          victim,
    output logic          victim_dirty,
    output logic [TB-1:0] victim_tag,
    input  logic          line_way,
    input  logic [IB-1:0] line_index,
    input  logic [WB-1:0] line_word,
    input  logic [TB-1:0] line_tag,
    input  logic          fill_we,
    input  logic          fill_done,
    input  logic [31:0]   fill_data,
    output logic [31:0]   back_data
);

    logic [TB-1:0] tags  [2][SETS];
    logic          valid [2][SETS];
    logic          dirty [2][SETS];
    logic          lru   [SETS];
    logic [31:0]   data  [2][SETS*LINE_WORDS];

    logic [IB-1:0] idx;
    logic [TB-1:0] tag;
    logic [WB-1:0] wofs;
    logic [1:0]    boff;
    logic          hit0;
    logic          hit1;
    logic          hway;
    logic [31:0]   word;
    logic [31:0]   lane;
    logic [31:0]   ext;
    logic [31:0]   merged;
    logic          sx;

    assign idx  = addr[2+WB +: IB];
    assign tag  = addr[2+WB+IB +: TB];
    assign wofs = addr[2 +: WB];
    assign boff = addr[1:0];

    assign hit0 = valid[0][idx] && (tags[0][idx] == tag);
    assign hit1 = valid[1][idx] && (tags[1][idx] == tag);
    assign hit  = acc && (hit0 || hit1);
    assign hway = hit1;
    assign word = data[hway][{idx, wofs}];

    always_comb begin
        lane   = word >> {boff, 3'b000};
        sx     = ~ubhw[UNS_BIT];
        ext    = word;
        merged = word;
        case (ubhw[1:0])
            SZ_BYTE: begin
                ext = {{24{sx & lane[7]}}, lane[7:0]};
                merged[{boff, 3'b000} +: 8] = data_w[7:0];
            end
            SZ_HALF: begin
                ext = {{16{sx & lane[15]}}, lane[15:0]};
                merged[{boff[1], 4'b0000} +: 16] = data_w[15:0];
            end
            default: merged = data_w;
        endcase
        data_r = (hit && !wr) ? ext : 32'd0;
    end

    // Prefer an empty way; otherwise evict the least recently used one.
    always_comb begin
        if (!valid[0][idx]) begin
            victim = 1'b0;
        end else if (!valid[1][idx]) begin
            victim = 1'b1;
        end else begin
            victim = lru[idx];
        end
        victim_dirty = valid[victim][idx] && dirty[victim][idx];
        victim_tag   = tags[victim][idx];
    end

    assign back_data = data[line_way][{line_index, line_word}];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[0][s] <= 1'b0;
                valid[1][s] <= 1'b0;
                dirty[0][s] <= 1'b0;
                dirty[1][s] <= 1'b0;
                lru[s]      <= 1'b0;
            end
        end else begin
            if (hit) begin
                lru[idx] <= ~hway;
                if (wr) begin
                    dirty[hway][idx] <= 1'b1;
                end
            end
            if (fill_done) begin
                valid[line_way][line_index] <= 1'b1;
                dirty[line_way][line_index] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hit && wr) begin
            data[hway][{idx, wofs}] <= merged;
        end
        if (fill_we) begin
            data[line_way][{line_index, line_word}] <= fill_data;
        end
        if (fill_done) begin
            tags[line_way][line_index] <= line_tag;
        end
    end

endmodule

// File: rtl/cmu.sv
// Cache miss unit: miss FSM, writeback/refill word counter and
// latched miss context in front of the cmu_cache storage.
module cmu
    import cmu_pkg::*;
#(
    parameter int LINE_WORDS = CMU_LINE_WORDS,
    parameter int SETS       = CMU_SETS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_rw,
    input  logic        en_r,
    input  logic        en_w,
    input  logic [2:0]  u_b_h_w,
    input  logic [31:0] data_w,
    output logic [31:0] data_r,
    output logic        stall,
    output logic        mem_cs_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TB = 30 - WB - IB;

    state_t        state;
    state_t        next;
    logic [WB-1:0] cnt;
    logic [TB-1:0] lat_tag;
    logic [TB-1:0] lat_vtag;
    logic [IB-1:0] lat_index;
    logic          lat_way;

    logic          req;
    logic          acc;
    logic          hit;
    logic          miss;
    logic          last;
    logic          victim;
    logic          victim_dirty;
    logic [TB-1:0] victim_tag;
    logic          fill_we;
    logic          fill_done;
    logic [31:0]   back_data;

    assign req  = en_r || en_w;
    assign acc  = !rst && (state == S_IDLE) && req;
    assign miss = acc && !hit;
    assign last = (cnt == WB'(LINE_WORDS - 1));

    cmu_cache #(
        .LINE_WORDS(LINE_WORDS),
        .SETS      (SETS)
    ) u_cache (
        .clk         (clk),
        .rst         (rst),
        .acc         (acc),
        .wr          (en_w),
        .addr        (addr_rw),
        .ubhw        (u_b_h_w),
        .data_w      (data_w),
        .hit         (hit),
        .data_r      (data_r),
        .victim      (victim),
        .victim_dirty(victim_dirty),
        .victim_tag  (victim_tag),
        .line_way    (lat_way),
        .line_index  (lat_index),
        .line_word   (cnt),
        .line_tag    (lat_tag),
        .fill_we     (fill_we),
        .fill_done   (fill_done),
        .fill_data   (mem_data_i),
        .back_data   (back_data)
    );

    always_comb begin
        next       = state;
        stall      = 1'b0;
        mem_cs_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = 32'd0;
        mem_data_o = 32'd0;
        fill_we    = 1'b0;
        fill_done  = 1'b0;
        if (!rst) begin
            unique case (state)
                S_IDLE: begin
                    if (miss) begin
                        stall = 1'b1;
                        next  = victim_dirty ? S_BACK : S_FILL;
                    end
                end
                S_BACK: begin
                    stall      = 1'b1;
                    mem_cs_o   = 1'b1;
                    mem_we_o   = 1'b1;
                    mem_addr_o = {lat_vtag, lat_index, cnt, 2'b00};
                    mem_data_o = back_data;
                    if (mem_ack_i && last) begin
                        next = S_FILL;
                    end
                end
                S_FILL: begin
                    stall      = 1'b1;
                    mem_cs_o   = 1'b1;
                    mem_addr_o = {lat_tag, lat_index, cnt, 2'b00};
                    fill_we    = mem_ack_i;
                    if (mem_ack_i && last) begin
                        fill_done = 1'b1;
                        next      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    stall = 1'b1;
                    next  = S_IDLE;
                end
                default: next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_tag   <= '0;
            lat_vtag  <= '0;
            lat_index <= '0;
            lat_way   <= 1'b0;
        end else begin
            state <= next;
            if (miss) begin
                lat_tag   <= addr_rw[2+WB+IB +: TB];
                lat_index <= addr_rw[2+WB +: IB];
                lat_way   <= victim;
                lat_vtag  <= victim_tag;
            end
            if ((state == S_BACK || state == S_FILL) && mem_ack_i) begin
                cnt <= last ? '0 : cnt + WB'(1);
            end
        end
    end

endmodule

// File: tb/tb_cmu.sv
// Scoreboarded random/directed bench for cmu against a flat-memory
// reference: loads must return the last value stored at that byte.
module tb_cmu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_rw;
    logic        en_r;
    logic        en_w;
    logic [2:0]  u_b_h_w;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;
    logic        mem_cs_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i = 32'd0;
    logic        mem_ack_i = 1'b0;

    cmu dut (
        .clk       (clk),
        .rst       (rst),
        .addr_rw   (addr_rw),
        .en_r      (en_r),
        .en_w      (en_w),
        .u_b_h_w   (u_b_h_w),
        .data_w    (data_w),
        .data_r    (data_r),
        .stall     (stall),
        .mem_cs_o  (mem_cs_o),
        .mem_we_o  (mem_we_o),
        .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i),
        .mem_ack_i (mem_ack_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h want %08h", name, act, exp);
    endtask

    // Backing memory (what the bus sees) and CPU-visible reference.
    logic [31:0] bmem [int unsigned];
    logic [31:0] rmem [int unsigned];

    function automatic logic [31:0] init_word(input int unsigned k);
        return (k * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] rd_b(input int unsigned k);
        return bmem.exists(k) ? bmem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] rd_r(input int unsigned k);
        return rmem.exists(k) ? rmem[k] : init_word(k);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a,
                                             input logic [2:0] sz);
        logic [31:0] w;
        logic [31:0] v;
        int          sh;
        w  = rd_r(a >> 2);
        sh = 8 * int'(a % 4);
        if (sz[1:0] == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (!sz[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz[1:0] == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            if (!sz[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic void ref_store(input logic [31:0] a,
                                      input logic [2:0] sz,
                                      input logic [31:0] d);
        logic [31:0] w;
        logic [31:0] m;
        int          sh;
        w  = rd_r(a >> 2);
        sh = 8 * int'(a % 4);
        if (sz[1:0] == 2'd0)      m = 32'hFF << sh;
        else if (sz[1:0] == 2'd1) m = 32'hFFFF << sh;
        else                      m = 32'hFFFF_FFFF;
        rmem[a >> 2] = (w & ~m) | ((d << sh) & m);
    endfunction

    // Memory responder: ack after a programmable number of wait cycles.
    int lat_min = 0;
    int lat_max = 0;
    int dly = 0;
    int wr_acks = 0;
    int cs_cycles = 0;
    logic [31:0] ack_addrs[$];

    always @(negedge clk) begin
        mem_ack_i = 1'b0;
        if (mem_cs_o) begin
            cs_cycles++;
            if (dly == 0) begin
                mem_ack_i = 1'b1;
                ack_addrs.push_back(mem_addr_o);
                if (mem_we_o) begin
                    bmem[mem_addr_o >> 2] = mem_data_o;
                    wr_acks++;
                end else begin
                    mem_data_i = rd_b(mem_addr_o >> 2);
                end
                dly = $urandom_range(lat_max, lat_min);
            end else begin
                dly--;
            end
        end
    end

    // Monitor: pops expected load data whenever a request completes.
    logic [31:0] exp_q[$];
    bit accepted = 1'b0;
    int stall_cycles = 0;

    always @(negedge clk) begin
        if (!rst && stall) stall_cycles++;
        if (!en_r && !en_w) check("idle data_r", data_r, 32'd0);
        if (!rst && !stall && en_r) begin
            if (exp_q.size() == 0) check("unexpected load", 32'd1, 32'd0);
            else check("load data", data_r, exp_q.pop_front());
            accepted = 1'b1;
        end
        if (!rst && !stall && en_w) accepted = 1'b1;
    end

    task automatic set_lat(input int lo, input int hi);
        lat_min = lo;
        lat_max = hi;
        dly = hi;
    endtask

    task automatic do_op(input bit w, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] d);
        int budget;
        accepted = 1'b0;
        addr_rw  = a;
        u_b_h_w  = sz;
        data_w   = d;
        if (w) ref_store(a, sz, d);
        else exp_q.push_back(ref_load(a, sz));
        en_w = w;
        en_r = !w;
        budget = 0;
        do begin
            @(posedge clk);
            budget++;
        end while (!accepted && budget < 200);
        if (!accepted) check("request timeout", 32'd0, 32'd1);
        #1;
        en_r = 1'b0;
        en_w = 1'b0;
    endtask

    task automatic do_reset();
        en_r = 1'b0;
        en_w = 1'b0;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst stall", {31'd0, stall}, 32'd0);
        check("rst cs", {31'd0, mem_cs_o}, 32'd0);
        check("rst we", {31'd0, mem_we_o}, 32'd0);
        check("rst addr", mem_addr_o, 32'd0);
        check("rst wdata", mem_data_o, 32'd0);
        rst = 1'b0;
        #2;
        check("post-rst stall", {31'd0, stall}, 32'd0);
        check("post-rst data_r", data_r, 32'd0);
        rmem = bmem;
        exp_q.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        addr_rw = 32'd0;
        en_r = 1'b0;
        en_w = 1'b0;
        u_b_h_w = 3'd0;
        data_w = 32'd0;
        do_reset();

        // Clean load miss with a 1-cycle memory.
        set_lat(0, 0);
        stall_cycles = 0;
        ack_addrs.delete();
        do_op(0, 32'h100, 3'd2, 0);
        check("miss stall cycles", stall_cycles, 6);
        check("fill count", ack_addrs.size(), 4);
        for (int i = 0; i < 4 && i < ack_addrs.size(); i++)
            check("fill addr", ack_addrs[i], 32'h100 + 4 * i);

        // Byte store hit then signed/unsigned reload.
        stall_cycles = 0;
        do_op(1, 32'h101, 3'd0, 32'h0000_00AB);
        do_op(0, 32'h101, 3'd0, 0);
        do_op(0, 32'h101, 3'd4, 0);
        check("hit stall cycles", stall_cycles, 0);

        // Both ways of set 0 dirty, then a third tag evicts the LRU one.
        do_op(1, 32'h400, 3'd2, 32'h1111_2222);
        do_op(1, 32'h800, 3'd2, 32'h3333_4444);
        check("no early writeback", wr_acks, 0);
        ack_addrs.delete();
        do_op(0, 32'hC00, 3'd2, 0);
        check("writeback count", wr_acks, 4);
        check("evict traffic", ack_addrs.size(), 8);
        for (int i = 0; i < 4 && i < ack_addrs.size(); i++)
            check("wb addr", ack_addrs[i], 32'h400 + 4 * i);
        if (ack_addrs.size() > 4) check("refill addr", ack_addrs[4], 32'hC00);
        check("wb data", rd_b(32'h400 >> 2), 32'h1111_2222);

        // Slow memory: 3 wait cycles per word.
        set_lat(3, 3);
        stall_cycles = 0;
        do_op(0, 32'h2044, 3'd2, 0);
        check("slow stall cycles", stall_cycles, 18);

        // Reset in the second refill cycle.
        set_lat(0, 0);
        addr_rw = 32'h3088;
        u_b_h_w = 3'd2;
        en_r = 1'b1;
        n = 0;
        while (!mem_ack_i && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("first ack seen", {31'd0, mem_ack_i}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst-fill stall", {31'd0, stall}, 32'd0);
        check("rst-fill cs", {31'd0, mem_cs_o}, 32'd0);
        en_r = 1'b0;
        rst = 1'b0;
        rmem = bmem;
        #1;
        stall_cycles = 0;
        do_op(0, 32'h3088, 3'd2, 0);
        check("reload misses", stall_cycles, 6);

        // Two tags in one set alternate without memory traffic.
        do_op(0, 32'h0000, 3'd2, 0);
        do_op(0, 32'h0400, 3'd2, 0);
        cs_cycles = 0;
        stall_cycles = 0;
        for (int i = 0; i < 10; i++)
            do_op(0, (i % 2 == 0) ? 32'h0004 : 32'h0408, 3'd2, 0);
        check("alt traffic", cs_cycles, 0);
        check("alt stall", stall_cycles, 0);

        // Random mix over a small footprint to force conflicts.
        set_lat(0, 3);
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            logic [1:0]  s;
            s = 2'($urandom_range(2, 0));
            a = ($urandom_range(3, 0) << 10) | ($urandom_range(3, 0) << 4)
              | ($urandom_range(3, 0) << 2);
            if (s == 2'd0) a = a | $urandom_range(3, 0);
            if (s == 2'd1) a = a | ($urandom_range(1, 0) << 1);
            sz = {1'($urandom_range(1, 0)), s};
            do_op(1'($urandom_range(1, 0)), a, sz, $urandom);
            if ($urandom_range(3, 0) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
